// File: rtl/mux8_frame_sequencer.sv
// Serializes 8-bit words onto the 8:1 mux select, one bit per BIT_CYCLES clocks.
// Define SEL_MSB_FIRST_EN to step Sel 7..0 instead of 0..7.
module mux8_frame_sequencer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       pause,
    output logic [7:0] A,
    output logic [2:0] Sel,
    output logic       bit_valid,
    output logic       bit_first,
    output logic       bit_last,
    output logic       busy
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

`ifdef SEL_MSB_FIRST_EN
    localparam logic [2:0] SEL_FIRST = 3'd7;
    localparam logic [2:0] SEL_LAST  = 3'd0;
`else
    localparam logic [2:0] SEL_FIRST = 3'd0;
    localparam logic [2:0] SEL_LAST  = 3'd7;
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    a_q, a_d;
    logic [2:0]    sel_q, sel_d;
    logic [CW-1:0] cyc_q, cyc_d;

    logic shifting;
    logic cyc_end;
    logic word_end;
    logic load;

    always_comb begin
        shifting = (state_q == SHIFT);
        cyc_end  = (cyc_q == CYC_LAST);
        word_end = shifting && cyc_end && (sel_q == SEL_LAST);
        in_ready = !shifting || (word_end && !pause);
        load     = in_valid && in_ready;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        sel_d   = sel_q;
        cyc_d   = cyc_q;
        if (load) begin
            state_d = SHIFT;
            a_d     = in_data;
            sel_d   = SEL_FIRST;
            cyc_d   = '0;
        end else if (shifting && !pause) begin
            if (cyc_end) begin
                cyc_d = '0;
                // Without a follow-on word, Sel parks on the last index in IDLE.
                if (sel_q == SEL_LAST) begin
                    state_d = IDLE;
                end else begin
`ifdef SEL_MSB_FIRST_EN
                    sel_d = sel_q - 3'd1;
`else
                    sel_d = sel_q + 3'd1;
`endif
                end
            end else begin
                cyc_d = cyc_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            sel_q   <= 3'd0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            sel_q   <= sel_d;
            cyc_q   <= cyc_d;
        end
    end

    assign A         = a_q;
    assign Sel       = sel_q;
    assign bit_valid = shifting;
    assign busy      = shifting;
    assign bit_first = shifting && (sel_q == SEL_FIRST);
    assign bit_last  = shifting && (sel_q == SEL_LAST);

endmodule

// File: tb/tb_mux8_frame_sequencer.sv
// Directed bench for mux8_frame_sequencer: one instance with BIT_CYCLES=1, one with 3.
module tb_mux8_frame_sequencer;

`ifdef SEL_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v1 = 1'b0, p1 = 1'b0, rdy1, bv1, bf1, bl1, busy1;
    logic [7:0] d1 = 8'h00, a1;
    logic [2:0] sel1;
    logic       v3 = 1'b0, p3 = 1'b0, rdy3, bv3, bf3, bl3, busy3;
    logic [7:0] d3 = 8'h00, a3;
    logic [2:0] sel3;

    int compared = 0;
    int mismatched = 0;

    mux8_frame_sequencer #(.BIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
        .pause(p1), .A(a1), .Sel(sel1), .bit_valid(bv1), .bit_first(bf1),
        .bit_last(bl1), .busy(busy1)
    );

    mux8_frame_sequencer #(.BIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
        .pause(p3), .A(a3), .Sel(sel3), .bit_valid(bv3), .bit_first(bf3),
        .bit_last(bl3), .busy(busy3)
    );

    function automatic logic [2:0] idx(input int k);
        return MSB ? 3'(7 - k) : 3'(k);
    endfunction

    task automatic drain3;
        v3 = 1'b0;
        for (int i = 0; i < 40 && bv3 === 1'b1; i++) @(negedge clk);
        compared++;
        if (bv3 !== 1'b0) begin
            mismatched++;
            $display("FAIL drain3_timeout: bit_valid=%b want 0", bv3);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        compared++;
        if ({rdy1, bv1, bf1, bl1, busy1} !== 5'b10000) begin
            mismatched++;
            $display("FAIL reset_flags1: got %b want 10000", {rdy1, bv1, bf1, bl1, busy1});
        end
        compared++;
        if ({a1, sel1} !== 11'h000) begin
            mismatched++;
            $display("FAIL reset_a_sel1: A=%h Sel=%0d want 00/0", a1, sel1);
        end
        compared++;
        if ({rdy3, bv3, bf3, bl3, busy3, a3, sel3} !== {5'b10000, 11'h000}) begin
            mismatched++;
            $display("FAIL reset_dut3: flags=%b A=%h Sel=%0d", {rdy3, bv3, bf3, bl3, busy3}, a3, sel3);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_word(input logic [7:0] w);
        logic [2:0] s;
        @(negedge clk);
        v1 = 1'b1;
        d1 = w;
        #1;
        compared++;
        if (rdy1 !== 1'b1) begin
            mismatched++;
            $display("FAIL single_ready_idle: in_ready=%b want 1", rdy1);
        end
        @(negedge clk);
        v1 = 1'b0;
        d1 = 8'h00;
        for (int k = 0; k < 8; k++) begin
            s = idx(k);
            compared++;
            if (sel1 !== s || bv1 !== 1'b1 || busy1 !== 1'b1 || a1 !== w) begin
                mismatched++;
                $display("FAIL single_bit%0d: Sel=%0d bv=%b busy=%b A=%h want Sel=%0d bv=1 busy=1 A=%h",
                         k, sel1, bv1, busy1, a1, s, w);
            end
            compared++;
            if (a1[sel1] !== w[s]) begin
                mismatched++;
                $display("FAIL single_F%0d: F=%b want %b", k, a1[sel1], w[s]);
            end
            compared++;
            if (bf1 !== (k == 0) || bl1 !== (k == 7)) begin
                mismatched++;
                $display("FAIL single_marks%0d: first=%b last=%b want %b %b", k, bf1, bl1, k == 0, k == 7);
            end
            @(negedge clk);
        end
        compared++;
        if (bv1 !== 1'b0 || rdy1 !== 1'b1) begin
            mismatched++;
            $display("FAIL single_end_idle: bv=%b in_ready=%b want 0 1", bv1, rdy1);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w;
        int j;
        @(negedge clk);
        v3 = 1'b1;
        d3 = 8'h0F;
        @(negedge clk);
        d3 = 8'hF0;
        for (int k = 0; k < 48; k++) begin
            j = k % 24;
            w = (k < 24) ? 8'h0F : 8'hF0;
            compared++;
            if (bv3 !== 1'b1 || sel3 !== idx(j / 3) || a3 !== w) begin
                mismatched++;
                $display("FAIL b2b_cycle%0d: bv=%b Sel=%0d A=%h want 1 %0d %h", k, bv3, sel3, a3, idx(j / 3), w);
            end
            compared++;
            if (rdy3 !== (j == 23)) begin
                mismatched++;
                $display("FAIL b2b_ready%0d: in_ready=%b want %b", k, rdy3, j == 23);
            end
            if (k == 24) v3 = 1'b0;
            @(negedge clk);
        end
        compared++;
        if (bv3 !== 1'b0 || rdy3 !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_end_idle: bv=%b in_ready=%b want 0 1", bv3, rdy3);
        end
    endtask

    task automatic test_pause;
        int u;
        @(negedge clk);
        v3 = 1'b1;
        d3 = 8'h5A;
        @(negedge clk);
        v3 = 1'b0;
        for (int t = 0; t < 29; t++) begin
            u = (t <= 10) ? t : ((t <= 15) ? 10 : t - 5);
            compared++;
            if (bv3 !== 1'b1 || sel3 !== idx(u / 3) || a3 !== 8'h5A) begin
                mismatched++;
                $display("FAIL pause_t%0d: bv=%b Sel=%0d A=%h want 1 %0d 5a", t, bv3, sel3, a3, idx(u / 3));
            end
            p3 = (t >= 10 && t < 15);
            @(negedge clk);
        end
        p3 = 1'b0;
        compared++;
        if (bv3 !== 1'b0) begin
            mismatched++;
            $display("FAIL pause_length: bv=%b want 0 after 29 cycles", bv3);
        end
    endtask

    task automatic test_midword_valid;
        @(negedge clk);
        v3 = 1'b1;
        d3 = 8'hC3;
        @(negedge clk);
        d3 = 8'h99;
        for (int k = 0; k < 24; k++) begin
            compared++;
            if (rdy3 !== (k == 23) || a3 !== 8'hC3) begin
                mismatched++;
                $display("FAIL midword_k%0d: in_ready=%b A=%h want %b c3", k, rdy3, a3, k == 23);
            end
            @(negedge clk);
        end
        v3 = 1'b0;
        compared++;
        if (a3 !== 8'h99 || sel3 !== idx(0) || bf3 !== 1'b1) begin
            mismatched++;
            $display("FAIL midword_next: A=%h Sel=%0d first=%b want 99 %0d 1", a3, sel3, bf3, idx(0));
        end
        drain3();
    endtask

    task automatic test_eow_pause;
        @(negedge clk);
        v3 = 1'b1;
        d3 = 8'h11;
        @(negedge clk);
        v3 = 1'b0;
        repeat (23) @(negedge clk);
        p3 = 1'b1;
        v3 = 1'b1;
        d3 = 8'h22;
        #1;
        compared++;
        if (rdy3 !== 1'b0) begin
            mismatched++;
            $display("FAIL eow_pause_ready: in_ready=%b want 0", rdy3);
        end
        @(negedge clk);
        compared++;
        if (a3 !== 8'h11 || sel3 !== idx(7) || bv3 !== 1'b1 || bl3 !== 1'b1) begin
            mismatched++;
            $display("FAIL eow_pause_hold: A=%h Sel=%0d bv=%b last=%b want 11 %0d 1 1", a3, sel3, bv3, bl3, idx(7));
        end
        p3 = 1'b0;
        #1;
        compared++;
        if (rdy3 !== 1'b1) begin
            mismatched++;
            $display("FAIL eow_unpause_ready: in_ready=%b want 1", rdy3);
        end
        @(negedge clk);
        v3 = 1'b0;
        compared++;
        if (a3 !== 8'h22 || sel3 !== idx(0) || bf3 !== 1'b1) begin
            mismatched++;
            $display("FAIL eow_next_load: A=%h Sel=%0d first=%b want 22 %0d 1", a3, sel3, bf3, idx(0));
        end
        drain3();
    endtask

    task automatic test_reset_midword;
        @(negedge clk);
        v1 = 1'b1;
        d1 = 8'hFF;
        @(negedge clk);
        v1 = 1'b0;
        repeat (5) @(negedge clk);
        compared++;
        if (sel1 !== idx(5) || bv1 !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_mid_pre: Sel=%0d bv=%b want %0d 1", sel1, bv1, idx(5));
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({rdy1, bv1, bf1, bl1, busy1, a1, sel1} !== {5'b10000, 11'h000}) begin
            mismatched++;
            $display("FAIL rst_mid_async: flags=%b A=%h Sel=%0d want 10000 00 0",
                     {rdy1, bv1, bf1, bl1, busy1}, a1, sel1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_word(8'hA5);
        test_single_word(8'h01);
        test_back_to_back();
        test_pause();
        test_midword_valid();
        test_eow_pause();
        test_reset_midword();
        test_single_word(8'h3C);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
